// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Pipeline hazard controller. It sits beside the decode stage and drives the
// fetch/decode register control pair (enb, haz), the PC enable, bubble
// insertion into decode/execute and the execute-stage hold. It resolves three
// hazard classes:
//   - load-use stalls (one bubble),
//   - taken-branch flushes (FLUSH_CYC cycles),
//   - multi-cycle execute waits (MC_LAT cycles).
// Outputs are combinational from the registered state and the current inputs,
// so every decision takes effect in the same cycle.
//
// Optional feature (macro PERF_CNT_EN): saturating stall/flush cycle counters
// on ports stall_cnt / flush_cnt. Without the macro those ports do not exist.
//
// Ports
//   cpu_clk      in   clock, rising edge
//   reset        in   asynchronous, active-low reset
//   rs1_d        in   [4:0] decode source register 1
//   rs2_d        in   [4:0] decode source register 2
//   use_rs2_d    in   decode instruction reads rs2
//   rd_e         in   [4:0] execute destination register
//   load_e       in   execute instruction is a load
//   br_taken_e   in   execute branch/jump resolved taken
//   mc_start_e   in   multi-cycle op entered execute (1-cycle pulse)
//   enb          out  [1:0] fetch/decode reg control: 01 load, 00 flush, 10 hold
//   haz          out  1 whenever enb != 01
//   pc_en        out  PC update enable
//   id_ex_flush  out  insert bubble into decode/execute register
//   ex_hold      out  hold the execute stage
//   stall_cnt    out  [CNT_W-1:0] cycles with enb==10 (PERF_CNT_EN only)
//   flush_cnt    out  [CNT_W-1:0] cycles with enb==00 (PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
  parameter int FLUSH_CYC = 2,
  parameter int MC_LAT    = 4
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W     = 32
`endif
) (
  input  logic             cpu_clk,
  input  logic             reset,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic             use_rs2_d,
  input  logic [4:0]       rd_e,
  input  logic             load_e,
  input  logic             br_taken_e,
  input  logic             mc_start_e,
  output logic [1:0]       enb,
  output logic             haz,
  output logic             pc_en,
  output logic             id_ex_flush,
  output logic             ex_hold
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    MC_WAIT
  } state_t;

  localparam logic [1:0] ENB_LOAD  = 2'b01;
  localparam logic [1:0] ENB_FLUSH = 2'b00;
  localparam logic [1:0] ENB_HOLD  = 2'b10;

  localparam int MAX_CYC = (FLUSH_CYC > MC_LAT) ? FLUSH_CYC : MC_LAT;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYC - 1);
  localparam logic [CW-1:0] MC_LOAD    = CW'(MC_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          luh;

  // x0 is never written, so a load targeting it can never create a hazard.
  assign luh = load_e && (rd_e != 5'd0) &&
               ((rd_e == rs1_d) || (use_rs2_d && (rd_e == rs2_d)));

  // Output decode: state plus current inputs, forced to the pass-through
  // pattern while reset is asserted.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    enb         = ENB_LOAD;
    pc_en       = 1'b1;
    id_ex_flush = 1'b0;
    ex_hold     = 1'b0;
    if (reset) begin
      unique case (state)
        RUN: begin
          if (br_taken_e) begin
            enb         = ENB_FLUSH;
            id_ex_flush = 1'b1;
          end else if (mc_start_e) begin
            enb     = ENB_HOLD;
            pc_en   = 1'b0;
            ex_hold = 1'b1;
          end else if (luh) begin
            enb         = ENB_HOLD;
            pc_en       = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        FLUSH: begin
          enb         = ENB_FLUSH;
          id_ex_flush = 1'b1;
        end
        MC_WAIT: begin
          enb     = ENB_HOLD;
          pc_en   = 1'b0;
          ex_hold = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign haz = (enb != ENB_LOAD);

  // State and down-counter. The first flush/hold cycle happens in RUN, so the
  // counter is loaded with the remaining cycle count and exits at cnt==1.
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      unique case (state)
        RUN: begin
          if (br_taken_e) begin
            if (FLUSH_CYC > 1) begin
              cnt   <= FLUSH_LOAD;
              state <= FLUSH;
            end
          end else if (mc_start_e) begin
            if (MC_LAT > 1) begin
              cnt   <= MC_LOAD;
              state <= MC_WAIT;
            end
          end
        end
        FLUSH, MC_WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // Saturating performance counters, one per non-load enb encoding.
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((enb == ENB_HOLD) && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if ((enb == ENB_FLUSH) && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_unit
//
// Self-checking bench for hazard_ctrl_unit: a table of single-cycle vectors,
// hand-written multi-cycle sequences, then random stimulus compared against a
// queue-based reference model (a taken branch or multi-cycle start schedules
// its remaining cycles into a queue of expected outputs).
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

  localparam int FLUSH_CYC = 2;
  localparam int MC_LAT    = 4;
`ifdef PERF_CNT_EN
  localparam int CNT_W     = 32;
`endif

  logic       cpu_clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic       use_rs2_d, load_e, br_taken_e, mc_start_e;
  logic [1:0] enb;
  logic       haz, pc_en, id_ex_flush, ex_hold;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl_unit #(
    .FLUSH_CYC (FLUSH_CYC),
    .MC_LAT    (MC_LAT)
`ifdef PERF_CNT_EN
    ,
    .CNT_W     (CNT_W)
`endif
  ) dut (
    .cpu_clk     (cpu_clk),
    .reset       (reset),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .use_rs2_d   (use_rs2_d),
    .rd_e        (rd_e),
    .load_e      (load_e),
    .br_taken_e  (br_taken_e),
    .mc_start_e  (mc_start_e),
    .enb         (enb),
    .haz         (haz),
    .pc_en       (pc_en),
    .id_ex_flush (id_ex_flush),
    .ex_hold     (ex_hold)
`ifdef PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 cpu_clk = ~cpu_clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] enb;
    logic       pc_en;
    logic       idf;
    logic       exh;
  } out_t;

  localparam out_t O_RUN   = out_t'({2'b01, 1'b1, 1'b0, 1'b0});
  localparam out_t O_FLUSH = out_t'({2'b00, 1'b1, 1'b1, 1'b0});
  localparam out_t O_MC    = out_t'({2'b10, 1'b0, 1'b0, 1'b1});
  localparam out_t O_LUH   = out_t'({2'b10, 1'b0, 1'b1, 1'b0});

  // Reference model: outputs already committed to future cycles, plus the
  // number of hold / flush cycles seen since reset.
  out_t        pend[$];
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic ld, input logic br, input logic mc);
    rs1_d      = r1;
    rs2_d      = r2;
    use_rs2_d  = u2;
    rd_e       = rd;
    load_e     = ld;
    br_taken_e = br;
    mc_start_e = mc;
  endtask

  // One clock cycle: drive at the falling edge, compare 1 ns later against the
  // model, then advance the model for the rising edge that follows.
  task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic ld, input logic br, input logic mc);
    out_t exp;
    logic hit;
    @(negedge cpu_clk);
    drive(r1, r2, u2, rd, ld, br, mc);
    #1;
    hit = ld && (rd != 5'd0) && ((rd == r1) || (u2 && (rd == r2)));
    if (pend.size() > 0) begin
      exp = pend.pop_front();
    end else if (br) begin
      exp = O_FLUSH;
      repeat (FLUSH_CYC - 1) pend.push_back(O_FLUSH);
    end else if (mc) begin
      exp = O_MC;
      repeat (MC_LAT - 1) pend.push_back(O_MC);
    end else if (hit) begin
      exp = O_LUH;
    end else begin
      exp = O_RUN;
    end
    check("enb", 32'(enb), 32'(exp.enb));
    check("haz", 32'(haz), 32'(exp.enb != 2'b01));
    check("pc_en", 32'(pc_en), 32'(exp.pc_en));
    check("id_ex_flush", 32'(id_ex_flush), 32'(exp.idf));
    check("ex_hold", 32'(ex_hold), 32'(exp.exh));
`ifdef PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
`endif
    if (exp.enb == 2'b10) m_stall++;
    if (exp.enb == 2'b00) m_flush++;
  endtask

  // Mid-cycle reset pulse with hazardous inputs applied: outputs must snap to
  // the pass-through pattern at once, whatever state the FSM was in.
  task automatic do_reset();
    @(negedge cpu_clk);
    #1;
    reset = 1'b0;
    drive(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1);
    #1;
    check("rst_enb", 32'(enb), 32'h1);
    check("rst_haz", 32'(haz), 32'h0);
    check("rst_pc_en", 32'(pc_en), 32'h1);
    check("rst_id_ex_flush", 32'(id_ex_flush), 32'h0);
    check("rst_ex_hold", 32'(ex_hold), 32'h0);
`ifdef PERF_CNT_EN
    check("rst_stall_cnt", stall_cnt, 32'h0);
    check("rst_flush_cnt", flush_cnt, 32'h0);
`endif
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    pend.delete();
    m_stall = 0;
    m_flush = 0;
  endtask

  typedef struct {
    string      name;
    logic [4:0] r1;
    logic [4:0] r2;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       br;
    logic       mc;
    out_t       exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{"idle",        5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[1]  = '{"luh_rs1",     5'd5, 5'd1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, O_LUH};
    vecs[2]  = '{"luh_rs2",     5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, O_LUH};
    vecs[3]  = '{"rs2_unused",  5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, O_RUN};
    vecs[4]  = '{"rd_x0",       5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, O_RUN};
    vecs[5]  = '{"not_load",    5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[6]  = '{"branch",      5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_FLUSH};
    vecs[7]  = '{"mc_start",    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_MC};
    vecs[8]  = '{"br_over_luh", 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, O_FLUSH};
    vecs[9]  = '{"br_over_mc",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_FLUSH};
    vecs[10] = '{"mc_over_luh", 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, O_MC};

    // Power-on reset with hazardous inputs present.
    reset = 1'b0;
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    #2;
    check("por_enb", 32'(enb), 32'h1);
    check("por_haz", 32'(haz), 32'h0);
    check("por_pc_en", 32'(pc_en), 32'h1);
    @(negedge cpu_clk);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;

    // Single-cycle decisions from the vector table, each from a clean RUN.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      step(vecs[i].r1, vecs[i].r2, vecs[i].u2, vecs[i].rd, vecs[i].ld, vecs[i].br, vecs[i].mc);
      check({vecs[i].name, "_enb"}, 32'(enb), 32'(vecs[i].exp.enb));
      check({vecs[i].name, "_pc_en"}, 32'(pc_en), 32'(vecs[i].exp.pc_en));
      check({vecs[i].name, "_id_ex_flush"}, 32'(id_ex_flush), 32'(vecs[i].exp.idf));
      check({vecs[i].name, "_ex_hold"}, 32'(ex_hold), 32'(vecs[i].exp.exh));
    end

    // Load-use: exactly one bubble, then normal flow.
    do_reset();
    step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    check("luh_seq_c0_enb", 32'(enb), 32'h2);
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("luh_seq_c1_enb", 32'(enb), 32'h1);

    // Taken branch: two flush cycles with pc_en high, inputs ignored in FLUSH.
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("br_seq_c0_enb", 32'(enb), 32'h0);
    check("br_seq_c0_pc_en", 32'(pc_en), 32'h1);
    step(5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
    check("br_seq_c1_enb", 32'(enb), 32'h0);
    check("br_seq_c1_pc_en", 32'(pc_en), 32'h1);

    // Multi-cycle op with load-use held: four holds, then one bubble.
    step(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < MC_LAT; c++) begin
      if (c > 0) step(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      check($sformatf("mc_seq_c%0d_enb", c), 32'(enb), 32'h2);
      check($sformatf("mc_seq_c%0d_ex_hold", c), 32'(ex_hold), 32'h1);
      check($sformatf("mc_seq_c%0d_id_ex_flush", c), 32'(id_ex_flush), 32'h0);
    end
    step(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    check("mc_seq_bubble_enb", 32'(enb), 32'h2);
    check("mc_seq_bubble_id_ex_flush", 32'(id_ex_flush), 32'h1);
    check("mc_seq_bubble_ex_hold", 32'(ex_hold), 32'h0);
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("mc_seq_done_enb", 32'(enb), 32'h1);
`ifdef PERF_CNT_EN
    check("perf_stall_total", stall_cnt, 32'd6);
    check("perf_flush_total", flush_cnt, 32'd2);
`endif

    // Reset while in MC_WAIT: immediate release, remaining wait discarded.
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("mcw_pre_reset_enb", 32'(enb), 32'h2);
    do_reset();
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("mcw_post_reset_enb", 32'(enb), 32'h1);

    // Random traffic against the queue model, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 11) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
